// File: rtl/cxu_types.sv
// Shared widths, function codes, status codes and response record for CXU responders.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cxu_types;

   localparam int CXU_ID_W           = 4;
   localparam int C_M_CXU_STATE_ID_W = 3;
   localparam int FUNC_W             = 3;
   localparam int INSN_W             = 32;
   localparam int DATA_W             = 32;
   localparam int REQ_ID_W           = 8;
   localparam int STATUS_W           = 2;

   typedef enum logic [FUNC_W-1:0] {
      ADD   = 3'd0,
      MAC   = 3'd1,
      RDACC = 3'd2,
      CLR   = 3'd3
   } cxu_mac_func_t;

   localparam logic [STATUS_W-1:0] STATUS_OK        = 2'd0;
   localparam logic [STATUS_W-1:0] STATUS_BAD_FUNC  = 2'd1;
   localparam logic [STATUS_W-1:0] STATUS_BAD_STATE = 2'd2;
   localparam logic [STATUS_W-1:0] STATUS_BAD_CXU   = 2'd3;

   typedef struct packed {
      logic [DATA_W-1:0]   data;
      logic [STATUS_W-1:0] status;
      logic [REQ_ID_W-1:0] id;
   } cxu_resp_t;

endpackage

// File: rtl/cxu_interface.sv
// CXU request/response channel bundle between a core (master) and a custom unit (slave).
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel.
interface cxu_interface;
   import cxu_types::*;

   logic                          req_valid;
   logic                          req_ready;
   logic [CXU_ID_W-1:0]           req_cxu;
   logic [C_M_CXU_STATE_ID_W-1:0] req_state;
   logic [FUNC_W-1:0]             req_func;
   logic [INSN_W-1:0]             req_insn;
   logic [DATA_W-1:0]             req_data0;
   logic [DATA_W-1:0]             req_data1;
   logic [REQ_ID_W-1:0]           req_id;

   logic                          resp_valid;
   logic                          resp_ready;
   logic [DATA_W-1:0]             resp_data;
   logic [STATUS_W-1:0]           resp_status;
   logic [REQ_ID_W-1:0]           resp_id;

   modport master (
      output req_valid, req_cxu, req_state, req_func, req_insn, req_data0, req_data1, req_id,
      input  req_ready,
      input  resp_valid, resp_data, resp_status, resp_id,
      output resp_ready
   );

   modport slave (
      input  req_valid, req_cxu, req_state, req_func, req_insn, req_data0, req_data1, req_id,
      output req_ready,
      output resp_valid, resp_data, resp_status, resp_id,
      input  resp_ready
   );

endinterface

// File: rtl/cxu_resp_fifo.sv
// Shift-register response FIFO; entry 0 is always the head, so outputs come straight from flops.
// Latency: a push is visible at the head the cycle after it when the FIFO was empty.
// Backpressure: the caller reserves a slot before pushing (credits), so push is never issued when full.
module cxu_resp_fifo
   import cxu_types::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_vld,
   input  cxu_resp_t        push_dat,
   input  logic             pop,
   output logic             head_vld,
   output cxu_resp_t        head_dat,
   output logic [CNT_W-1:0] count
);

   cxu_resp_t        ent [DEPTH];
   logic [CNT_W-1:0] cnt;
   logic             pop_ok;
   logic [CNT_W-1:0] wr_idx;

   assign pop_ok = pop && (cnt != '0);
   // A simultaneous pop shifts everything down one slot, so the new entry lands one lower.
   assign wr_idx = pop_ok ? cnt - CNT_W'(1) : cnt;

   // Shift on pop, write the tail slot on push, keep the occupancy count.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
         cnt <= '0;
      end else begin
         if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) ent[i] <= ent[i+1];
            ent[DEPTH-1] <= '0;
         end
         if (push_vld) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (CNT_W'(i) == wr_idx) ent[i] <= push_dat;
            end
         end
         cnt <= cnt + CNT_W'(push_vld) - CNT_W'(pop_ok);
      end
   end

   assign head_vld = (cnt != '0);
   assign head_dat = ent[0];
   assign count    = cnt;

endmodule

// File: rtl/cxu_mac_unit.sv
// CXU responder: ADD / MAC / RDACC / CLR against per-state accumulators, in-order responses.
// Latency: accept in cycle N gives resp_valid in N+2 with an empty queue (E1 regs, E2 RMW + push).
// Backpressure: req_ready is a credit check on registered counts; each accept reserves a FIFO slot.
module cxu_mac_unit
   import cxu_types::*;
#(
   parameter int CXU_ID     = 0,
   parameter int NUM_STATES = 4,
   parameter int RESP_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   cxu_interface.slave  cxu,
   output logic         busy
);

   localparam int               CNT_W        = $clog2(RESP_DEPTH + 1);
   localparam logic [31:0]      NUM_STATES_U = NUM_STATES;

   logic                          accept;
   logic                          pop;
   logic [CNT_W-1:0]              fifo_count;
   logic [CNT_W-1:0]              used;
   logic [STATUS_W-1:0]           req_status;
   logic [DATA_W-1:0]             req_prod;

   logic                          e1_vld;
   logic [C_M_CXU_STATE_ID_W-1:0] e1_state;
   logic [FUNC_W-1:0]             e1_func;
   logic [DATA_W-1:0]             e1_data0;
   logic [DATA_W-1:0]             e1_data1;
   logic [DATA_W-1:0]             e1_prod;
   logic [STATUS_W-1:0]           e1_status;
   logic [REQ_ID_W-1:0]           e1_id;

   logic [DATA_W-1:0]             acc [NUM_STATES];
   logic [DATA_W-1:0]             acc_rd;
   logic [DATA_W-1:0]             acc_wdat;
   logic                          acc_we;
   logic [DATA_W-1:0]             e2_result;

   cxu_resp_t                     push_dat;
   cxu_resp_t                     head_dat;
   logic                          head_vld;
   logic                          unused_insn;

   assign unused_insn = ^cxu.req_insn;

   // Slots spoken for: queued responses plus the one request sitting in E1.
   assign used          = fifo_count + CNT_W'(e1_vld);
   assign cxu.req_ready = !rst && (used != CNT_W'(RESP_DEPTH));
   assign accept        = cxu.req_valid && cxu.req_ready;
   assign pop           = head_vld && cxu.resp_ready;
   assign req_prod      = cxu.req_data0 * cxu.req_data1;

   // Classify the incoming request; earlier checks shadow later ones.
   always_comb begin
      req_status = STATUS_OK;
      if (cxu.req_cxu != CXU_ID_W'(CXU_ID))
         req_status = STATUS_BAD_CXU;
      else if (32'(cxu.req_state) >= NUM_STATES_U)
         req_status = STATUS_BAD_STATE;
      else if (cxu.req_func > FUNC_W'(3))
         req_status = STATUS_BAD_FUNC;
   end

   // E1: capture the accepted request, its status and the truncated product.
   always_ff @(posedge clk) begin
      if (rst) begin
         e1_vld    <= 1'b0;
         e1_state  <= '0;
         e1_func   <= '0;
         e1_data0  <= '0;
         e1_data1  <= '0;
         e1_prod   <= '0;
         e1_status <= '0;
         e1_id     <= '0;
      end else begin
         e1_vld <= accept;
         if (accept) begin
            e1_state  <= cxu.req_state;
            e1_func   <= cxu.req_func;
            e1_data0  <= cxu.req_data0;
            e1_data1  <= cxu.req_data1;
            e1_prod   <= req_prod;
            e1_status <= req_status;
            e1_id     <= cxu.req_id;
         end
      end
   end

   // E2: read the addressed accumulator and compute result / write-back; errors yield 0, no write.
   always_comb begin
      acc_rd    = '0;
      acc_we    = 1'b0;
      acc_wdat  = '0;
      e2_result = '0;
      for (int i = 0; i < NUM_STATES; i++) begin
         if (e1_state == C_M_CXU_STATE_ID_W'(i)) acc_rd = acc[i];
      end
      if (e1_status == STATUS_OK) begin
         case (e1_func)
            ADD:     e2_result = e1_data0 + e1_data1;
            MAC: begin
               acc_wdat  = acc_rd + e1_prod;
               acc_we    = 1'b1;
               e2_result = acc_wdat;
            end
            RDACC:   e2_result = acc_rd;
            CLR:     acc_we    = 1'b1;
            default: e2_result = '0;
         endcase
      end
   end

   // Accumulator write-back; read and write share E2 so consecutive MACs chain without forwarding.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_STATES; i++) acc[i] <= '0;
      end else if (e1_vld && acc_we) begin
         for (int i = 0; i < NUM_STATES; i++) begin
            if (e1_state == C_M_CXU_STATE_ID_W'(i)) acc[i] <= acc_wdat;
         end
      end
   end

   assign push_dat = {e2_result, e1_status, e1_id};

   cxu_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .CNT_W (CNT_W)
   ) u_resp_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (e1_vld),
      .push_dat (push_dat),
      .pop      (pop),
      .head_vld (head_vld),
      .head_dat (head_dat),
      .count    (fifo_count)
   );

   assign cxu.resp_valid  = head_vld;
   assign cxu.resp_data   = head_dat.data;
   assign cxu.resp_status = head_dat.status;
   assign cxu.resp_id     = head_dat.id;
   assign busy            = e1_vld || (fifo_count != '0);

endmodule

// File: tb/tb_cxu_mac_unit.sv
// Bench for cxu_mac_unit: vector table plus hand-written latency, backpressure and reset sequences.
// Latency: responses are matched in order against a queue of expected records.
// Backpressure: resp_ready is held low in one sequence to fill every credit.
module tb_cxu_mac_unit;
   import cxu_types::*;

   localparam int NUM_STATES = 4;
   localparam int RESP_DEPTH = 4;
   localparam int CXU_ID     = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;

   cxu_interface cxu_if();

   cxu_mac_unit #(
      .CXU_ID     (CXU_ID),
      .NUM_STATES (NUM_STATES),
      .RESP_DEPTH (RESP_DEPTH)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .cxu  (cxu_if),
      .busy (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cxu;
      logic [2:0]  state;
      logic [2:0]  func;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [31:0] exp_data;
      logic [1:0]  exp_status;
   } vec_t;

   vec_t      vecs [22];
   cxu_resp_t sb [$];
   cxu_resp_t mon_e;
   int        errors = 0;
   int        checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] c, input logic [2:0] s, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ed, input logic [1:0] es);
      vec_t r;
      r.cxu = c; r.state = s; r.func = f; r.d0 = a; r.d1 = b;
      r.exp_data = ed; r.exp_status = es;
      return r;
   endfunction

   // Scoreboard: every response handshake is compared with the oldest expected record.
   always @(negedge clk) begin
      if (!rst && cxu_if.resp_valid && cxu_if.resp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got id 0x%02h data 0x%08h, expected no response",
                     cxu_if.resp_id, cxu_if.resp_data);
         end else begin
            mon_e = sb.pop_front();
            check("resp_data",   32'(cxu_if.resp_data),   32'(mon_e.data));
            check("resp_status", 32'(cxu_if.resp_status), 32'(mon_e.status));
            check("resp_id",     32'(cxu_if.resp_id),     32'(mon_e.id));
         end
      end
   end

   // Present one request, wait (bounded) for the handshake, record the expected response.
   task automatic send(input logic [3:0] c, input logic [2:0] s, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic [7:0] id,
                       input logic [31:0] ed, input logic [1:0] es);
      bit ok;
      cxu_if.req_cxu   = c;
      cxu_if.req_state = s;
      cxu_if.req_func  = f;
      cxu_if.req_data0 = a;
      cxu_if.req_data1 = b;
      cxu_if.req_id    = id;
      cxu_if.req_insn  = $urandom;
      cxu_if.req_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (cxu_if.req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: req_ready stayed 0 for id 0x%02h, expected 1", id);
      end else begin
         sb.push_back('{data: ed, status: es, id: id});
         @(posedge clk);
         #1;
      end
      cxu_if.req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: still %0d responses outstanding, busy=%0b, expected 0 and 0",
                  name, sb.size(), busy);
      end
   endtask

   initial begin
      int n_acc;
      int first_block;

      // ids 0x20+i; statuses: 0 ok, 1 bad func, 2 bad state, 3 bad cxu
      vecs[0]  = mk(4'd0, 3'd0, 3'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 2'd0);
      vecs[1]  = mk(4'd0, 3'd1, 3'd1, 32'd3, 32'd4, 32'd12, 2'd0);
      vecs[2]  = mk(4'd0, 3'd1, 3'd1, 32'd5, 32'd6, 32'd42, 2'd0);
      vecs[3]  = mk(4'd0, 3'd1, 3'd1, 32'd2, 32'd2, 32'd46, 2'd0);
      vecs[4]  = mk(4'd0, 3'd1, 3'd2, 32'd9, 32'd9, 32'd46, 2'd0);
      vecs[5]  = mk(4'd0, 3'd2, 3'd1, 32'd7, 32'd1, 32'd7, 2'd0);
      vecs[6]  = mk(4'd0, 3'd1, 3'd3, 32'd1, 32'd1, 32'd0, 2'd0);
      vecs[7]  = mk(4'd0, 3'd1, 3'd2, 32'd0, 32'd0, 32'd0, 2'd0);
      vecs[8]  = mk(4'd0, 3'd0, 3'd2, 32'd0, 32'd0, 32'd0, 2'd0);
      vecs[9]  = mk(4'd0, 3'd2, 3'd2, 32'd0, 32'd0, 32'd7, 2'd0);
      vecs[10] = mk(4'd1, 3'd2, 3'd1, 32'd5, 32'd5, 32'd0, 2'd3);
      vecs[11] = mk(4'd0, 3'd4, 3'd1, 32'd5, 32'd5, 32'd0, 2'd2);
      vecs[12] = mk(4'd0, 3'd2, 3'd7, 32'd5, 32'd5, 32'd0, 2'd1);
      vecs[13] = mk(4'd1, 3'd5, 3'd7, 32'd5, 32'd5, 32'd0, 2'd3);
      vecs[14] = mk(4'd0, 3'd4, 3'd7, 32'd5, 32'd5, 32'd0, 2'd2);
      vecs[15] = mk(4'd1, 3'd2, 3'd3, 32'd0, 32'd0, 32'd0, 2'd3);
      vecs[16] = mk(4'd0, 3'd2, 3'd2, 32'd0, 32'd0, 32'd7, 2'd0);
      vecs[17] = mk(4'd0, 3'd3, 3'd1, 32'h0001_0000, 32'h0001_0000, 32'd0, 2'd0);
      vecs[18] = mk(4'd0, 3'd3, 3'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 2'd0);
      vecs[19] = mk(4'd0, 3'd3, 3'd1, 32'd2, 32'd1, 32'd1, 2'd0);
      vecs[20] = mk(4'd0, 3'd0, 3'd0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 2'd0);
      vecs[21] = mk(4'd0, 3'd3, 3'd2, 32'd0, 32'd0, 32'd1, 2'd0);

      cxu_if.req_valid  = 1'b0;
      cxu_if.req_cxu    = '0;
      cxu_if.req_state  = '0;
      cxu_if.req_func   = '0;
      cxu_if.req_insn   = '0;
      cxu_if.req_data0  = '0;
      cxu_if.req_data1  = '0;
      cxu_if.req_id     = '0;
      cxu_if.resp_ready = 1'b1;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready",   32'(cxu_if.req_ready),   32'd0);
      check("rst_resp_valid",  32'(cxu_if.resp_valid),  32'd0);
      check("rst_resp_data",   32'(cxu_if.resp_data),   32'd0);
      check("rst_resp_status", 32'(cxu_if.resp_status), 32'd0);
      check("rst_resp_id",     32'(cxu_if.resp_id),     32'd0);
      check("rst_busy",        32'(busy),               32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", 32'(cxu_if.req_ready), 32'd1);

      // Latency: ADD accepted at N must appear at N+2
      @(posedge clk);
      #1;
      cxu_if.req_cxu   = 4'd0;
      cxu_if.req_state = 3'd0;
      cxu_if.req_func  = 3'd0;
      cxu_if.req_data0 = 32'hFFFF_FFFF;
      cxu_if.req_data1 = 32'd2;
      cxu_if.req_id    = 8'd5;
      cxu_if.req_valid = 1'b1;
      @(negedge clk);
      check("lat_req_ready", 32'(cxu_if.req_ready), 32'd1);
      sb.push_back('{data: 32'd1, status: 2'd0, id: 8'd5});
      @(posedge clk);
      #1 cxu_if.req_valid = 1'b0;
      @(negedge clk);
      check("lat_n1_resp_valid", 32'(cxu_if.resp_valid), 32'd0);
      @(negedge clk);
      check("lat_n2_resp_valid", 32'(cxu_if.resp_valid), 32'd1);
      check("lat_n2_resp_data",  32'(cxu_if.resp_data),  32'd1);
      check("lat_n2_resp_id",    32'(cxu_if.resp_id),    32'd5);
      wait_idle("lat_idle");

      // Vector table, issued back to back
      @(posedge clk);
      #1;
      for (int i = 0; i < 22; i++) begin
         send(vecs[i].cxu, vecs[i].state, vecs[i].func, vecs[i].d0, vecs[i].d1,
              8'(8'h20 + i), vecs[i].exp_data, vecs[i].exp_status);
      end
      wait_idle("table_idle");

      // Backpressure: resp_ready low, stream RDACC state 2 (holds 7)
      @(posedge clk);
      #1;
      cxu_if.resp_ready = 1'b0;
      cxu_if.req_cxu    = 4'd0;
      cxu_if.req_state  = 3'd2;
      cxu_if.req_func   = 3'd2;
      cxu_if.req_id     = 8'h40;
      cxu_if.req_valid  = 1'b1;
      n_acc       = 0;
      first_block = -1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (cxu_if.req_ready) begin
            sb.push_back('{data: 32'd7, status: 2'd0, id: cxu_if.req_id});
            n_acc++;
         end else if (first_block < 0) begin
            first_block = c;
         end
         @(posedge clk);
         #1 cxu_if.req_id = 8'(8'h40 + n_acc);
      end
      cxu_if.req_valid = 1'b0;
      check("bp_accepts",     32'(n_acc),       32'(RESP_DEPTH));
      check("bp_first_block", 32'(first_block), 32'(RESP_DEPTH));
      @(negedge clk);
      check("bp_req_ready",  32'(cxu_if.req_ready),  32'd0);
      check("bp_resp_valid", 32'(cxu_if.resp_valid), 32'd1);
      check("bp_busy",       32'(busy),              32'd1);
      check("bp_queued",     32'(sb.size()),         32'(RESP_DEPTH));
      repeat (3) @(negedge clk);
      check("bp_hold_id",   32'(cxu_if.resp_id),   32'h40);
      check("bp_hold_data", 32'(cxu_if.resp_data), 32'd7);
      @(posedge clk);
      #1 cxu_if.resp_ready = 1'b1;
      wait_idle("bp_drain");

      // Reset with three responses queued
      @(posedge clk);
      #1 cxu_if.resp_ready = 1'b0;
      send(4'd0, 3'd0, 3'd1, 32'd1, 32'd9, 8'h60, 32'd9, 2'd0);
      send(4'd0, 3'd3, 3'd1, 32'd2, 32'd2, 8'h61, 32'd5, 2'd0);
      send(4'd0, 3'd0, 3'd0, 32'd3, 32'd4, 8'h62, 32'd7, 2'd0);
      @(posedge clk);
      @(negedge clk);
      check("pre_rst_resp_valid", 32'(cxu_if.resp_valid), 32'd1);
      check("pre_rst_busy",       32'(busy),              32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      check("mid_rst_resp_valid", 32'(cxu_if.resp_valid), 32'd0);
      check("mid_rst_busy",       32'(busy),              32'd0);
      check("mid_rst_req_ready",  32'(cxu_if.req_ready),  32'd0);
      rst = 1'b0;
      cxu_if.resp_ready = 1'b1;
      @(negedge clk);
      check("after_rst_req_ready", 32'(cxu_if.req_ready), 32'd1);
      @(posedge clk);
      #1;
      for (int s = 0; s < NUM_STATES; s++) begin
         send(4'd0, 3'(s), 3'd2, 32'd0, 32'd0, 8'(8'h70 + s), 32'd0, 2'd0);
      end
      wait_idle("rst_idle");
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
